// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and build defaults for the fetch-side instruction buffer.
// Defines CPU_WIDTH, IFB_DEPTH and RESET_PC unless the build already has them.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef IFB_DEPTH
`define IFB_DEPTH 4
`endif
`ifndef RESET_PC
`define RESET_PC 32'h0000_0000
`endif

package inst_fetch_buf_pkg;

  localparam int XLEN = `CPU_WIDTH;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } ifb_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous in-order FIFO with a single-cycle flush.
// Ports: clk, rst_n, flush, push, pop, wdata, rdata (head), count, empty, full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch buffer: sequential imem reads, in-order queue, decode handshake, redirect flush.
// Ports: imem req/addr/gnt/rvalid/rdata, redirect_i/_pc_i, inst valid/ready/inst/pc. Macro ROOTH_IFB_BYPASS_EN.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef IFB_DEPTH
`define IFB_DEPTH 4
`endif
`ifndef RESET_PC
`define RESET_PC 32'h0000_0000
`endif

module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int                   DEPTH    = `IFB_DEPTH,
  parameter logic [`CPU_WIDTH-1:0] RESET_PC = `RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_o,
  output logic [`CPU_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [`CPU_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [`CPU_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  output logic [`CPU_WIDTH-1:0] inst_o,
  output logic [`CPU_WIDTH-1:0] inst_pc_o,
  input  logic                  inst_ready_i
);

  localparam int CW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW:0]     drop;
  logic [CW:0]     outstanding;
  logic [CW:0]     dcnt;
  logic [CW+1:0]   used;
  logic [XLEN-1:0] flight_pc;
  logic            pc_empty;
  logic            pc_full;
  logic            d_empty;
  logic            d_full;
  logic            gnt_ok;
  logic            resp;
  logic            keep;
  logic            wr_en;
  logic            pop_en;
  ifb_entry_t      head;
  ifb_entry_t      wr_data;

  // The PC queue occupancy is the outstanding-request count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (gnt_ok),
    .pop   (resp),
    .wdata (fetch_pc),
    .rdata (flight_pc),
    .count (outstanding),
    .empty (pc_empty),
    .full  (pc_full)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_i),
    .push  (wr_en),
    .pop   (pop_en),
    .wdata (wr_data),
    .rdata (head),
    .count (dcnt),
    .empty (d_empty),
    .full  (d_full)
  );

  // Credit: queued plus in-flight never exceeds DEPTH.
  assign used = {1'b0, dcnt} + {1'b0, outstanding};

  assign imem_req_o  = rst_n && !redirect_i && !pc_full
                    && (used < (CW+2)'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign gnt_ok      = imem_req_o && imem_gnt_i;

  // Responses with nothing in flight are ignored.
  assign resp    = imem_rvalid_i && !pc_empty;
  assign keep    = resp && (drop == '0) && !redirect_i;
  assign wr_data = '{inst: imem_rdata_i, pc: flight_pc};

`ifdef ROOTH_IFB_BYPASS_EN
  logic byp;

  assign byp          = d_empty && keep;
  assign inst_valid_o = !d_empty || byp;
  assign inst_o       = byp ? imem_rdata_i : head.inst;
  assign inst_pc_o    = byp ? flight_pc : head.pc;
  assign wr_en        = keep && !(byp && inst_ready_i);
  assign pop_en       = !d_empty && inst_ready_i;
`else
  assign inst_valid_o = !d_empty;
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;
  assign wr_en        = keep;
  assign pop_en       = inst_valid_o && inst_ready_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_i) begin
      fetch_pc <= align_pc(redirect_pc_i);
      drop     <= outstanding - (CW+1)'(resp);
    end else begin
      if (gnt_ok) fetch_pc <= fetch_pc + XLEN'(4);
      if (resp && (drop != '0))
        drop <= drop - (CW+1)'(1);
    end
  end

  a_rvalid_expected: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> !pc_empty
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    wr_en |-> !d_full
  );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Randomized bench for inst_fetch_buf against a queue-level fetch model.
// Drives a latency-programmable in-order memory and a random decode sink.
module tb_inst_fetch_buf;
  import inst_fetch_buf_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  inst_fetch_buf #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } fl_t;

  fl_t         fl_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] fa;
  logic [31:0] exp_pc;
  int          cyc;
  int          last_due;
  int          checks;
  int          errors;

  int          gnt_pct;
  int          rdy_pct;
  int          lat_lo;
  int          lat_hi;
  int          redir_pct;
  bit          force_redir;
  logic [31:0] force_pc;

  int          grants;
  int          first_grant;
  int          first_valid;
  bit          got_deliv;
  logic [31:0] first_deliv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fl_q.delete();
    buf_q.delete();
    fa          = RPC;
    exp_pc      = RPC;
    cyc         = 0;
    last_due    = 0;
    grants      = 0;
    first_grant = -1;
    first_valid = -1;
    got_deliv   = 0;
    first_deliv = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    inst_ready_i  = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, RPC);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", inst_pc_o, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    bit          rv;
    bit          req_e;
    bit          val_e;
    bit          byp;
    bit          hs;
    logic [31:0] hp;
    fl_t         e;
    int          due;
    @(negedge clk);
    redirect_i    = force_redir ||
                    ($urandom_range(99) < 32'(redir_pct));
    redirect_pc_i = force_redir ? force_pc : $urandom;
    force_redir   = 0;
    imem_gnt_i    = $urandom_range(99) < 32'(gnt_pct);
    inst_ready_i  = $urandom_range(99) < 32'(rdy_pct);
    rv = (fl_q.size() > 0) && (fl_q[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(fl_q[0].pc) : $urandom;
    #1;
    req_e = !redirect_i &&
            (buf_q.size() + fl_q.size() < DEPTH);
    chk("req", {31'd0, imem_req_o}, {31'd0, req_e});
    chk("addr", imem_addr_o, fa);
    byp = 0;
`ifdef ROOTH_IFB_BYPASS_EN
    byp = (buf_q.size() == 0) && rv && !fl_q[0].stale
          && !redirect_i;
`endif
    val_e = (buf_q.size() != 0) || byp;
    chk("valid", {31'd0, inst_valid_o}, {31'd0, val_e});
    if (inst_valid_o && first_valid < 0) first_valid = cyc;
    if (val_e) begin
      hp = (buf_q.size() != 0) ? buf_q[0] : fl_q[0].pc;
      chk("head_pc", inst_pc_o, hp);
      chk("head_inst", inst_o, mem_word(hp));
    end
    hs = val_e && inst_ready_i;
    if (hs) begin
      chk("order", inst_pc_o, exp_pc);
      exp_pc = exp_pc + 32'd4;
      if (!got_deliv) begin
        got_deliv   = 1;
        first_deliv = inst_pc_o;
      end
      if (buf_q.size() != 0) void'(buf_q.pop_front());
    end
    if (rv) begin
      e = fl_q.pop_front();
      if (!e.stale && !redirect_i && !(byp && inst_ready_i))
        buf_q.push_back(e.pc);
    end
    if (req_e && imem_gnt_i) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      fl_q.push_back('{pc: fa, due: due, stale: 1'b0});
      fa = fa + 32'd4;
      grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    if (redirect_i) begin
      buf_q.delete();
      foreach (fl_q[i]) fl_q[i].stale = 1;
      fa     = {redirect_pc_i[31:2], 2'b00};
      exp_pc = fa;
    end
    cyc++;
  endtask

  task automatic knobs(input int g, input int r, input int lo,
                       input int hi, input int rd);
    gnt_pct   = g;
    rdy_pct   = r;
    lat_lo    = lo;
    lat_hi    = hi;
    redir_pct = rd;
  endtask

  initial begin
    int n;
    logic [31:0] a0;
    checks      = 0;
    errors      = 0;
    force_redir = 0;
    force_pc    = '0;
    model_reset();

    // steady fetch
    knobs(100, 100, 1, 1, 0);
    do_reset();
    repeat (12) step();
    chk("first_grant", 32'(first_grant), 32'd0);
`ifdef ROOTH_IFB_BYPASS_EN
    chk("first_valid", 32'(first_valid), 32'd1);
`else
    chk("first_valid", 32'(first_valid), 32'd2);
`endif
    chk("steady_grants", 32'(grants), 32'd12);
    chk("first_deliv", first_deliv, RPC);

    // back-pressure
    knobs(100, 0, 1, 1, 0);
    do_reset();
    repeat (10) step();
    chk("bp_grants", 32'(grants), 32'(DEPTH));
    chk("bp_req", {31'd0, imem_req_o}, 32'd0);
    chk("bp_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("bp_head", inst_pc_o, 32'h0);
    chk("bp_addr", imem_addr_o, 32'h10);
    knobs(100, 100, 1, 1, 0);
    repeat (10) step();
    chk("bp_drain", first_deliv, 32'h0);

    // redirect with three in flight
    knobs(100, 100, 3, 3, 0);
    do_reset();
    n = 0;
    while (fl_q.size() < 3 && n < 20) begin
      step();
      n++;
    end
    chk("rd_inflight", 32'(fl_q.size()), 32'd3);
    got_deliv   = 0;
    force_redir = 1;
    force_pc    = 32'h100;
    step();
    repeat (15) step();
    chk("rd_delivered", {31'd0, got_deliv}, 32'd1);
    chk("rd_first_pc", first_deliv, 32'h100);

    // alignment and wrap
    knobs(100, 100, 1, 1, 0);
    force_redir = 1;
    force_pc    = 32'h203;
    step();
    @(posedge clk);
    #1;
    chk("align", imem_addr_o, 32'h200);
    knobs(0, 100, 1, 1, 0);
    repeat (4) step();
    force_redir = 1;
    force_pc    = 32'hFFFF_FFFC;
    step();
    @(posedge clk);
    #1;
    chk("wrap_a", imem_addr_o, 32'hFFFF_FFFC);
    knobs(100, 100, 1, 1, 0);
    step();
    @(posedge clk);
    #1;
    chk("wrap_b", imem_addr_o, 32'h0);

    // grant stall
    knobs(0, 100, 1, 1, 0);
    repeat (4) step();
    a0 = imem_addr_o;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", imem_addr_o, a0);
      chk("stall_req", {31'd0, imem_req_o}, 32'd1);
    end
    chk("stall_fl", 32'(fl_q.size()), 32'd0);

    // reset mid-operation
    knobs(100, 0, 2, 2, 0);
    do_reset();
    n = 0;
    while (!(buf_q.size() == 3 && fl_q.size() == 1) && n < 20) begin
      step();
      n++;
    end
    chk("mid_buf", 32'(buf_q.size()), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mid_req", {31'd0, imem_req_o}, 32'd0);
    chk("mid_addr", imem_addr_o, RPC);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    knobs(100, 100, 1, 1, 0);
    repeat (8) step();
    chk("mid_restart", first_deliv, RPC);

    // random traffic
    do_reset();
    for (int k = 0; k < 15; k++) begin
      knobs(int'($urandom_range(100, 30)),
            int'($urandom_range(100, 20)),
            1, int'($urandom_range(4, 1)), 3);
      repeat (200) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
